// File: rtl/ranged_bus_pipe_if.sv
// ranged_bus_pipe_if
// Handshake and data bundle for ranged_bus_pipe.
//   in_valid / in_ready   upstream valid/ready pair
//   i0 [MSB:LSB]          lane 0 input, descending range
//   i1 [LSB:MSB]          lane 1 input, ascending range
//   out_valid / out_ready downstream valid/ready pair
//   o0 [MSB:LSB]          lane 0 output, descending range
//   o1 [LSB:MSB]          lane 1 output, ascending range
// The master modport is the side that drives beats in and consumes beats out.
// The slave modport is the pipeline itself.
interface ranged_bus_pipe_if #(
  parameter int MSB = 2,
  parameter int LSB = -2
);
  logic           in_valid;
  logic           in_ready;
  logic [MSB:LSB] i0;
  logic [LSB:MSB] i1;
  logic           out_valid;
  logic           out_ready;
  logic [MSB:LSB] o0;
  logic [LSB:MSB] o1;

  modport master (
    output in_valid, i0, i1, out_ready,
    input  in_ready, out_valid, o0, o1
  );

  modport slave (
    input  in_valid, i0, i1, out_ready,
    output in_ready, out_valid, o0, o1
  );
endinterface

// File: rtl/ranged_bus_pipe.sv
// ranged_bus_pipe
// Elastic valid/ready retiming pipeline of DEPTH stages carrying two lanes
// with user-chosen bit ranges (lane 0 descending, lane 1 ascending, negative
// indices allowed). MODE "CROSS" swaps the lanes by index number on entry.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   bus        ranged_bus_pipe_if.slave (in/out handshakes and lane data)
//   occupancy  number of valid stages, registered
//   stall_cnt  [15:0] saturating count of cycles with out_valid & !out_ready,
//              present only when RANGED_BUS_PIPE_STALL_CNT_EN is defined
module ranged_bus_pipe #(
  parameter int                 MSB        = 2,
  parameter int                 LSB        = -2,
  parameter int                 DEPTH      = 2,
  parameter string              MODE       = "PASS",
  parameter logic [MSB-LSB:0]   INIT_VALUE = '0,
  localparam int                OCC_W      = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ranged_bus_pipe_if.slave     bus,
`ifdef RANGED_BUS_PIPE_STALL_CNT_EN
  output logic [15:0]          stall_cnt,
`endif
  output logic [OCC_W-1:0]     occupancy
);

  logic [DEPTH-1:0] v_q;
  logic [MSB:LSB]   a_q [DEPTH];
  logic [LSB:MSB]   b_q [DEPTH];

  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] src_v;
  logic [MSB:LSB]   src_a [DEPTH];
  logic [LSB:MSB]   src_b [DEPTH];
  logic [MSB:LSB]   entry_a;
  logic [LSB:MSB]   entry_b;
  logic             in_xfer;
  logic             out_xfer;

  // Lane mapping works by index number, not vector position: because the
  // lanes run in opposite directions, a plain vector copy would mirror bits.
  always_comb begin
    entry_a = bus.i0;
    entry_b = bus.i1;
    if (MODE == "CROSS") begin
      for (int k = LSB; k <= MSB; k++) begin
        entry_a[k] = bus.i1[k];
        entry_b[k] = bus.i0[k];
      end
    end
  end

  // A stage may load when it or any stage downstream of it is empty, or when
  // the consumer takes the head beat. This is the unrolled form of
  // adv_k = !v_k | adv_(k+1), written without a self-referencing vector.
  always_comb begin
    adv = '0;
    for (int k = 0; k < DEPTH; k++) begin
      adv[k] = bus.out_ready;
      for (int j = k; j < DEPTH; j++) begin
        if (!v_q[j]) adv[k] = 1'b1;
      end
    end
  end

  // Source of each stage: the upstream port for s0, the previous stage
  // otherwise.
  always_comb begin
    src_v[0] = bus.in_valid;
    src_a[0] = entry_a;
    src_b[0] = entry_b;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k] = v_q[k-1];
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
    end
  end

  assign in_xfer  = bus.in_valid & adv[0];
  assign out_xfer = v_q[DEPTH-1] & bus.out_ready;

  // Stage registers. Data is only overwritten by a valid beat, so an emptied
  // stage keeps showing the last beat it held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        a_q[k] <= INIT_VALUE;
        b_q[k] <= INIT_VALUE;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (adv[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            a_q[k] <= src_a[k];
            b_q[k] <= src_b[k];
          end
        end
      end
    end
  end

  // Occupancy tracks the number of valid stages from the two transfer events.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occupancy <= '0;
    end else if (in_xfer && !out_xfer) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (out_xfer && !in_xfer) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

`ifdef RANGED_BUS_PIPE_STALL_CNT_EN
  // Counts cycles where the head beat is blocked; sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (v_q[DEPTH-1] && !bus.out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

  assign bus.in_ready  = adv[0];
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.o0        = a_q[DEPTH-1];
  assign bus.o1        = b_q[DEPTH-1];

endmodule

// File: doc/ranged_bus_pipe.md
Name: ranged_bus_pipe

Overview:
Parametrised, elastic valid/ready pipeline carrying two lanes with user-defined bit ranges. Lane 0 is descending [MSB:LSB] and lane 1 is ascending [LSB:MSB]; negative indices are allowed. It is the registered, configurable-range successor of the fixed two-bus model cell. It is used as a stress block for range-aware netlist handling and as a generic bus retimer.

Parameters:
MSB, 2, upper index of both lanes; signed integer; MSB >= LSB.
LSB, -2, lower index of both lanes; W = MSB-LSB+1, 1..64.
DEPTH, 2, number of register stages, 1..8.
MODE, "PASS", string: "PASS" keeps lanes; "CROSS" swaps lanes at the input stage.
INIT_VALUE, 0, W-bit reset value of every data register in both lanes.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  upstream has a beat
in_ready  out  1  block accepts the beat this cycle
i0  in  [MSB:LSB]  lane 0 data, descending range
i1  in  [LSB:MSB]  lane 1 data, ascending range
out_valid  out  1  output beat present
out_ready  in  1  downstream accepts
o0  out  [MSB:LSB]  lane 0 output, descending range
o1  out  [LSB:MSB]  lane 1 output, ascending range
occupancy  out  $clog2(DEPTH+1)  number of valid stages

Behaviour:
- Interface is fixed: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset: all stage valid bits 0, all data regs INIT_VALUE. Outputs: out_valid=0, o0=o1=INIT_VALUE, occupancy=0, in_ready=1.
- Stages s0..s(DEPTH-1). Each stage holds {valid, a[MSB:LSB], b[LSB:MSB]}. Outputs are driven directly from s(DEPTH-1); no combinational path from i0/i1 to o0/o1.
- Stage k advances when it is empty, or when stage k+1 advances / downstream accepts: adv_k = !v_k | adv_(k+1), with adv_DEPTH = out_ready. in_ready = adv_0.
- Bubbles collapse: an empty stage always accepts.
- Handshake: transfer occurs when valid & ready are both high at a clock edge.
- Once asserted, out_valid holds with stable o0/o1 until out_ready is sampled high.
- Latency: DEPTH cycles from input transfer to out_valid with no backpressure. Throughput is 1 beat/cycle at full occupancy with out_ready=1.
- Mapping is by index number, not vector position, applied on entry to s0:
  - PASS: a[k]=i0[k], b[k]=i1[k].
  - CROSS: a[k]=i1[k], b[k]=i0[k], for every k in LSB..MSB.
- Full (occupancy=DEPTH) with out_ready=0: in_ready=0; i0/i1 are ignored.
- Full with out_ready=1: simultaneous output and input transfer; occupancy is unchanged.
- Empty: out_valid=0; o0/o1 retain last-held stage data (INIT_VALUE after reset).
- occupancy is registered and updated every edge: +1 on input transfer only, -1 on output transfer only, unchanged on both or neither.
- rst_n asserted mid-stream: immediately (asynchronously) clears valids and data to reset values. In-flight beats are discarded, not flushed.
- MSB=LSB (W=1) and DEPTH=1 are legal; DEPTH=1 still sustains full throughput via the adv chain.

Optional Feature:
Macro RANGED_BUS_PIPE_STALL_CNT_EN.
- Defined: adds output stall_cnt [15:0]. Reset 0. Increments each cycle with out_valid=1 and out_ready=0, saturates at 16'hFFFF, and never wraps.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, MSB=2 LSB=-2 DEPTH=2 INIT_VALUE=5'h0A -> out_valid=0, o0=5'h0A, o1=5'h0A, occupancy=0, in_ready=1.
- PASS, single beat i0=5'b10110, i1=5'b10110, out_ready=1 -> out_valid high exactly 2 cycles later, o0=5'b10110, o1=5'b10110, occupancy back to 0 one cycle after.
- CROSS, same stimulus -> o0=5'b01101 (o0[2]=i1[2]=0 … o0[-2]=i1[-2]=1), o1=5'b01101.
- Backpressure: out_ready=0, push 3 beats into DEPTH=2 -> third beat refused (in_ready=0), occupancy=2. Release out_ready -> beats emerge in order, one per cycle.
- Full throughput: DEPTH=3, 10 back-to-back beats (values 0..9) with out_ready=1 -> outputs 0..9 on consecutive cycles after 3-cycle latency. in_ready stays 1; occupancy steady at 3.
- Mid-stream rst_n low for 1 cycle with occupancy=2 -> out_valid and occupancy drop to 0 asynchronously, o0/o1=INIT_VALUE, no stale beat appears afterwards. With RANGED_BUS_PIPE_STALL_CNT_EN, 70000 stall cycles -> stall_cnt=16'hFFFF.
